// File: rtl/sc_regshifter_seq_if.sv
// Handshake and data bus of the sequential multi-mode shift register.
// master: datapath control side; slave: the shifter itself.
interface sc_regshifter_seq_if #(
  parameter int unsigned DATAWIDTH_BUS               = 32,
  parameter int unsigned DATAWIDTH_REGSHIFTER_AMOUNT = 5,
  parameter int unsigned DATAWIDTH_REGSHIFTER_MODE   = 3
);
  logic                                   SC_RegSHIFTERSEQ_Load_InLow;
  logic                                   SC_RegSHIFTERSEQ_Start_InHigh;
  logic [DATAWIDTH_REGSHIFTER_MODE-1:0]   SC_RegSHIFTERSEQ_Mode_In;
  logic [DATAWIDTH_REGSHIFTER_AMOUNT-1:0] SC_RegSHIFTERSEQ_Amount_In;
  logic                                   SC_RegSHIFTERSEQ_SerialIn;
  logic [DATAWIDTH_BUS-1:0]               SC_RegSHIFTERSEQ_DataBUS_In;
  logic [DATAWIDTH_BUS-1:0]               SC_RegSHIFTERSEQ_DataBUS_Out;
  logic                                   SC_RegSHIFTERSEQ_Busy_OutHigh;
  logic                                   SC_RegSHIFTERSEQ_Done_OutHigh;
  logic                                   SC_RegSHIFTERSEQ_Carry_Out;
  logic                                   SC_RegSHIFTERSEQ_Zero_Out;

  modport master (
    output SC_RegSHIFTERSEQ_Load_InLow, SC_RegSHIFTERSEQ_Start_InHigh,
           SC_RegSHIFTERSEQ_Mode_In, SC_RegSHIFTERSEQ_Amount_In,
           SC_RegSHIFTERSEQ_SerialIn, SC_RegSHIFTERSEQ_DataBUS_In,
    input  SC_RegSHIFTERSEQ_DataBUS_Out, SC_RegSHIFTERSEQ_Busy_OutHigh,
           SC_RegSHIFTERSEQ_Done_OutHigh, SC_RegSHIFTERSEQ_Carry_Out,
           SC_RegSHIFTERSEQ_Zero_Out
  );

  modport slave (
    input  SC_RegSHIFTERSEQ_Load_InLow, SC_RegSHIFTERSEQ_Start_InHigh,
           SC_RegSHIFTERSEQ_Mode_In, SC_RegSHIFTERSEQ_Amount_In,
           SC_RegSHIFTERSEQ_SerialIn, SC_RegSHIFTERSEQ_DataBUS_In,
    output SC_RegSHIFTERSEQ_DataBUS_Out, SC_RegSHIFTERSEQ_Busy_OutHigh,
           SC_RegSHIFTERSEQ_Done_OutHigh, SC_RegSHIFTERSEQ_Carry_Out,
           SC_RegSHIFTERSEQ_Zero_Out
  );
endinterface

// File: rtl/sc_regshifter_seq.sv
// Sequential multi-mode shift register: load a word, then shift it one bit
// position per clock for a programmable count, with a busy/done handshake.
// Optional carry/zero flags are built only when REGSHIFTERSEQ_FLAGS_EN is defined.
module sc_regshifter_seq #(
  parameter int unsigned DATAWIDTH_BUS               = 32,
  parameter int unsigned DATAWIDTH_REGSHIFTER_AMOUNT = 5,
  parameter int unsigned DATAWIDTH_REGSHIFTER_MODE   = 3
) (
  input  logic                SC_RegSHIFTERSEQ_CLOCK_50,
  input  logic                SC_RegSHIFTERSEQ_Reset_InHigh,
  sc_regshifter_seq_if.slave  bus_io
);
  localparam int unsigned W  = DATAWIDTH_BUS;
  localparam int unsigned AW = DATAWIDTH_REGSHIFTER_AMOUNT;
  localparam int unsigned MW = DATAWIDTH_REGSHIFTER_MODE;

  localparam logic [MW-1:0] ModeSll = MW'(0);
  localparam logic [MW-1:0] ModeSrl = MW'(1);
  localparam logic [MW-1:0] ModeSra = MW'(2);
  localparam logic [MW-1:0] ModeRol = MW'(3);
  localparam logic [MW-1:0] ModeRor = MW'(4);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  logic          clk, rst;
  logic          load_n, start, serial;
  logic [MW-1:0] mode_in;
  logic [AW-1:0] amount_in;
  logic [W-1:0]  data_in;

  assign clk       = SC_RegSHIFTERSEQ_CLOCK_50;
  assign rst       = SC_RegSHIFTERSEQ_Reset_InHigh;
  assign load_n    = bus_io.SC_RegSHIFTERSEQ_Load_InLow;
  assign start     = bus_io.SC_RegSHIFTERSEQ_Start_InHigh;
  assign serial    = bus_io.SC_RegSHIFTERSEQ_SerialIn;
  assign mode_in   = bus_io.SC_RegSHIFTERSEQ_Mode_In;
  assign amount_in = bus_io.SC_RegSHIFTERSEQ_Amount_In;
  assign data_in   = bus_io.SC_RegSHIFTERSEQ_DataBUS_In;

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [MW-1:0] mode_q, mode_d;
  logic [W-1:0]  data_q, data_d;
  logic [W-1:0]  shifted;
`ifdef REGSHIFTERSEQ_FLAGS_EN
  logic          carry_q, carry_d;
  logic          shift_out;
  logic          shift_valid;
`endif

  // One-position shift of the register according to the latched mode.
  always_comb begin
    shifted = data_q;
`ifdef REGSHIFTERSEQ_FLAGS_EN
    shift_out   = 1'b0;
    shift_valid = 1'b1;
`endif
    case (mode_q)
      ModeSll: shifted = {data_q[W-2:0], serial};
      ModeSrl: shifted = {serial, data_q[W-1:1]};
      ModeSra: shifted = {data_q[W-1], data_q[W-1:1]};
      ModeRol: shifted = {data_q[W-2:0], data_q[W-1]};
      ModeRor: shifted = {data_q[0], data_q[W-1:1]};
      default: shifted = data_q;
    endcase
`ifdef REGSHIFTERSEQ_FLAGS_EN
    case (mode_q)
      ModeSll, ModeRol:          shift_out = data_q[W-1];
      ModeSrl, ModeSra, ModeRor: shift_out = data_q[0];
      default:                   shift_valid = 1'b0;
    endcase
`endif
  end

  // Next-state and datapath update for the IDLE/SHIFT/DONE sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    data_d  = data_q;
`ifdef REGSHIFTERSEQ_FLAGS_EN
    carry_d = carry_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (!load_n) begin
          data_d = data_in;
`ifdef REGSHIFTERSEQ_FLAGS_EN
          carry_d = 1'b0;
`endif
        end else if (start) begin
          if (amount_in == '0) begin
            state_d = StDone;
          end else begin
            mode_d  = mode_in;
            cnt_d   = amount_in;
            state_d = StShift;
          end
        end
      end
      StShift: begin
        data_d = shifted;
`ifdef REGSHIFTERSEQ_FLAGS_EN
        if (shift_valid) carry_d = shift_out;
`endif
        cnt_d = cnt_q - AW'(1);
        if (cnt_q == AW'(1)) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; synchronous reset abandons any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      mode_q  <= '0;
      data_q  <= '0;
`ifdef REGSHIFTERSEQ_FLAGS_EN
      carry_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      data_q  <= data_d;
`ifdef REGSHIFTERSEQ_FLAGS_EN
      carry_q <= carry_d;
`endif
    end
  end

  assign bus_io.SC_RegSHIFTERSEQ_DataBUS_Out  = data_q;
  assign bus_io.SC_RegSHIFTERSEQ_Busy_OutHigh = (state_q == StShift);
  assign bus_io.SC_RegSHIFTERSEQ_Done_OutHigh = (state_q == StDone);
`ifdef REGSHIFTERSEQ_FLAGS_EN
  assign bus_io.SC_RegSHIFTERSEQ_Carry_Out = carry_q;
  assign bus_io.SC_RegSHIFTERSEQ_Zero_Out  = (data_q == '0);
`else
  assign bus_io.SC_RegSHIFTERSEQ_Carry_Out = 1'b0;
  assign bus_io.SC_RegSHIFTERSEQ_Zero_Out  = 1'b0;
`endif
endmodule

// File: tb/tb_sc_regshifter_seq.sv
// Directed plus randomized bench for sc_regshifter_seq (32-bit bus, 6-bit amount
// so that amounts beyond the bus width can be exercised).
module tb_sc_regshifter_seq;
  localparam int W  = 32;
  localparam int AW = 6;
  localparam int MW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sc_regshifter_seq_if #(
    .DATAWIDTH_BUS(W), .DATAWIDTH_REGSHIFTER_AMOUNT(AW), .DATAWIDTH_REGSHIFTER_MODE(MW)
  ) bus ();

  sc_regshifter_seq #(
    .DATAWIDTH_BUS(W), .DATAWIDTH_REGSHIFTER_AMOUNT(AW), .DATAWIDTH_REGSHIFTER_MODE(MW)
  ) dut (
    .SC_RegSHIFTERSEQ_CLOCK_50    (clk),
    .SC_RegSHIFTERSEQ_Reset_InHigh(rst),
    .bus_io                       (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] exp_val = '0;
  logic         exp_carry = 1'b0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Result of shifting v by n positions in one go.
  function automatic logic [W-1:0] model_shift(logic [W-1:0] v, int mode, int n, logic s);
    int k;
    logic [W-1:0] ones;
    ones = '1;
    case (mode)
      0: if (n >= W) return {W{s}};
         else return W'((64'(v) << n) | (s ? ((64'(1) << n) - 1) : 64'(0)));
      1: if (n >= W) return {W{s}};
         else return (v >> n) | (s ? ~(ones >> n) : '0);
      2: return W'($signed(v) >>> ((n > W - 1) ? W - 1 : n));
      3: begin k = n % W; return W'((64'(v) << k) | (64'(v) >> (W - k))); end
      4: begin k = n % W; return W'((64'(v) >> k) | (64'(v) << (W - k))); end
      default: return v;
    endcase
  endfunction

  // Last bit to leave the register over an n-position shift.
  function automatic logic model_carry(logic [W-1:0] v, int mode, int n, logic s, logic c);
    if (n == 0 || mode > 4) return c;
    case (mode)
      0: return (n <= W) ? v[W - n] : s;
      1: return (n <= W) ? v[n - 1] : s;
      2: return (n <= W) ? v[n - 1] : v[W-1];
      3: return v[(W - n % W) % W];
      default: return v[(n - 1) % W];
    endcase
  endfunction

  task automatic chk_flags(input string tag);
`ifdef REGSHIFTERSEQ_FLAGS_EN
    chk({tag, "_carry"}, W'(bus.SC_RegSHIFTERSEQ_Carry_Out), W'(exp_carry));
    chk({tag, "_zero"}, W'(bus.SC_RegSHIFTERSEQ_Zero_Out), W'(exp_val == '0));
`else
    chk({tag, "_carry"}, W'(bus.SC_RegSHIFTERSEQ_Carry_Out), '0);
    chk({tag, "_zero"}, W'(bus.SC_RegSHIFTERSEQ_Zero_Out), '0);
`endif
  endtask

  // All steps start and end just after a falling edge.
  task automatic do_load(input logic [W-1:0] d);
    bus.SC_RegSHIFTERSEQ_Load_InLow = 1'b0;
    bus.SC_RegSHIFTERSEQ_DataBUS_In = d;
    @(negedge clk);
    bus.SC_RegSHIFTERSEQ_Load_InLow = 1'b1;
    exp_val   = d;
    exp_carry = 1'b0;
    chk("load_out", bus.SC_RegSHIFTERSEQ_DataBUS_Out, exp_val);
  endtask

  task automatic run_op(input int mode, input int amt, input logic s, input bit load_mid);
    int cnt;
    bus.SC_RegSHIFTERSEQ_Mode_In     = MW'(mode);
    bus.SC_RegSHIFTERSEQ_Amount_In   = AW'(amt);
    bus.SC_RegSHIFTERSEQ_SerialIn    = s;
    bus.SC_RegSHIFTERSEQ_Start_InHigh = 1'b1;
    @(negedge clk);
    bus.SC_RegSHIFTERSEQ_Start_InHigh = 1'b0;
    // Inputs wander while shifting; they must not matter.
    bus.SC_RegSHIFTERSEQ_Mode_In   = MW'($urandom);
    bus.SC_RegSHIFTERSEQ_Amount_In = AW'($urandom);
    exp_carry = model_carry(exp_val, mode, amt, s, exp_carry);
    exp_val   = model_shift(exp_val, mode, amt, s);
    cnt = 0;
    while (bus.SC_RegSHIFTERSEQ_Busy_OutHigh === 1'b1 && cnt < 100) begin
      chk("done_low_while_busy", W'(bus.SC_RegSHIFTERSEQ_Done_OutHigh), '0);
      if (load_mid && cnt == 0) begin
        bus.SC_RegSHIFTERSEQ_Load_InLow = 1'b0;
        bus.SC_RegSHIFTERSEQ_DataBUS_In = $urandom;
      end else begin
        bus.SC_RegSHIFTERSEQ_Load_InLow = 1'b1;
      end
      cnt++;
      @(negedge clk);
    end
    bus.SC_RegSHIFTERSEQ_Load_InLow = 1'b1;
    chk("busy_cycles", W'(cnt), W'(amt));
    chk("done_pulse", W'(bus.SC_RegSHIFTERSEQ_Done_OutHigh), 1);
    chk("result", bus.SC_RegSHIFTERSEQ_DataBUS_Out, exp_val);
    chk_flags("op");
    @(negedge clk);
    chk("done_single", W'(bus.SC_RegSHIFTERSEQ_Done_OutHigh), '0);
    chk("idle_after", W'(bus.SC_RegSHIFTERSEQ_Busy_OutHigh), '0);
  endtask

  initial begin
    int done_seen;
    bus.SC_RegSHIFTERSEQ_Load_InLow   = 1'b1;
    bus.SC_RegSHIFTERSEQ_Start_InHigh = 1'b0;
    bus.SC_RegSHIFTERSEQ_Mode_In      = '0;
    bus.SC_RegSHIFTERSEQ_Amount_In    = '0;
    bus.SC_RegSHIFTERSEQ_SerialIn     = 1'b0;
    bus.SC_RegSHIFTERSEQ_DataBUS_In   = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_out", bus.SC_RegSHIFTERSEQ_DataBUS_Out, '0);
    chk("rst_busy", W'(bus.SC_RegSHIFTERSEQ_Busy_OutHigh), '0);
    chk("rst_done", W'(bus.SC_RegSHIFTERSEQ_Done_OutHigh), '0);
    chk_flags("rst");
    do_load(32'hA5A5_0001);

    do_load(32'h8000_000F);
    run_op(0, 4, 1'b1, 1'b0);
    chk("sll4_value", bus.SC_RegSHIFTERSEQ_DataBUS_Out, 32'h0000_00FF);
    do_load(32'h8000_0010);
    run_op(2, 3, 1'b0, 1'b0);
    chk("sra3_value", bus.SC_RegSHIFTERSEQ_DataBUS_Out, 32'hF000_0002);
    do_load(32'h0000_0001);
    run_op(4, 36, 1'b0, 1'b0);
    chk("ror36_value", bus.SC_RegSHIFTERSEQ_DataBUS_Out, 32'h1000_0000);
    run_op(3, 0, 1'b1, 1'b0);
    run_op(6, 5, 1'b1, 1'b0);
    chk("reserved_hold", bus.SC_RegSHIFTERSEQ_DataBUS_Out, 32'h1000_0000);

    // Load and start together: load wins, no operation.
    bus.SC_RegSHIFTERSEQ_Load_InLow   = 1'b0;
    bus.SC_RegSHIFTERSEQ_DataBUS_In   = 32'h1234_5678;
    bus.SC_RegSHIFTERSEQ_Start_InHigh = 1'b1;
    bus.SC_RegSHIFTERSEQ_Amount_In    = AW'(5);
    @(negedge clk);
    bus.SC_RegSHIFTERSEQ_Load_InLow   = 1'b1;
    bus.SC_RegSHIFTERSEQ_Start_InHigh = 1'b0;
    exp_val = 32'h1234_5678;
    exp_carry = 1'b0;
    chk("ld_st_out", bus.SC_RegSHIFTERSEQ_DataBUS_Out, exp_val);
    chk("ld_st_busy", W'(bus.SC_RegSHIFTERSEQ_Busy_OutHigh), '0);
    chk("ld_st_done", W'(bus.SC_RegSHIFTERSEQ_Done_OutHigh), '0);
    @(negedge clk);
    chk("ld_st_idle", W'(bus.SC_RegSHIFTERSEQ_Busy_OutHigh), '0);

    run_op(1, 7, 1'b1, 1'b1);

    for (int i = 0; i < 24; i++) begin
      do_load((i % 6 == 5) ? 32'h0 : 32'($urandom));
      run_op(int'($urandom_range(7)), int'($urandom_range(63)), 1'($urandom), 1'($urandom));
    end

    // Reset during the second of eight shift cycles abandons the operation.
    do_load(32'hDEAD_BEEF);
    bus.SC_RegSHIFTERSEQ_Mode_In      = '0;
    bus.SC_RegSHIFTERSEQ_Amount_In    = AW'(8);
    bus.SC_RegSHIFTERSEQ_Start_InHigh = 1'b1;
    @(negedge clk);
    bus.SC_RegSHIFTERSEQ_Start_InHigh = 1'b0;
    chk("rst_mid_busy1", W'(bus.SC_RegSHIFTERSEQ_Busy_OutHigh), 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_val = '0;
    exp_carry = 1'b0;
    chk("rst_mid_out", bus.SC_RegSHIFTERSEQ_DataBUS_Out, '0);
    chk("rst_mid_busy", W'(bus.SC_RegSHIFTERSEQ_Busy_OutHigh), '0);
    chk_flags("rst_mid");
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.SC_RegSHIFTERSEQ_Done_OutHigh !== 1'b0) done_seen++;
      @(negedge clk);
    end
    chk("rst_mid_no_done", W'(done_seen), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
